// File: rtl/axi4_lite_sram_read_slave_if.sv
// axi4_lite_sram_read_slave_if: AXI4-lite read address/data channel bundle; master drives AR_*/R_READY, slave drives AR_READY/R_*
interface axi4_lite_sram_read_slave_if;
  logic [63:0] AR_ADDR;
  logic        AR_VALID;
  logic [2:0]  AR_PROT;
  logic        AR_READY;
  logic [63:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        R_VALID;
  logic        R_READY;
  modport master (output AR_ADDR, AR_VALID, AR_PROT, R_READY, input AR_READY, R_DATA, R_RESP, R_VALID);
  modport slave (input AR_ADDR, AR_VALID, AR_PROT, R_READY, output AR_READY, R_DATA, R_RESP, R_VALID);
endinterface

// File: rtl/axi4_lite_sram_read_slave.sv
// axi4_lite_sram_read_slave: one-outstanding AXI4-lite read slave over a 64-bit word SRAM; ports clk, rst_n (sync active-low), bus (slave modport: AR_*, R_*), LD_EN/LD_IDX/LD_DATA preload; define AXI_RD_SLAVE_RAND_DELAY_EN to add 0..7 LFSR cycles to LATENCY
module axi4_lite_sram_read_slave #(
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi4_lite_sram_read_slave_if.slave bus,
  input  logic                  LD_EN,
  input  logic [DEPTH_LOG2-1:0] LD_IDX,
  input  logic [63:0]           LD_DATA
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
`ifdef AXI_RD_SLAVE_RAND_DELAY_EN
  localparam int CW = 4;
`else
  localparam int CW = 3;
`endif
  logic [1:0]    state;
  logic [CW-1:0] cnt, d;
  logic [63:0]   addr, src, off, rd_data, r_data;
  logic [1:0]    rd_resp, r_resp;
  logic          dec, mis, enter, ar_ready, r_valid, ar_hs, unused;
  logic [63:0]   mem [2**DEPTH_LOG2];
`ifdef AXI_RD_SLAVE_RAND_DELAY_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk)
    if (!rst_n) lfsr <= 8'hA5;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign d = CW'(LATENCY) + CW'(lfsr[2:0]);
`else
  assign d = CW'(LATENCY);
`endif
  assign ar_hs = state == IDLE && bus.AR_VALID && ar_ready;
  // a zero delay decodes the live AR_ADDR, otherwise the captured one
  always_comb begin
    src     = state == IDLE ? bus.AR_ADDR : addr;
    off     = src - BASE_ADDR;
    dec     = src < BASE_ADDR || (off >> (DEPTH_LOG2 + 3)) != 64'd0;
    mis     = src[2:0] != 3'd0;
    rd_resp = dec ? 2'b11 : mis ? 2'b10 : 2'b00;
    rd_data = (dec || mis) ? 64'd0 : mem[off[DEPTH_LOG2+2:3]];
    enter   = ar_hs ? d == '0 : state == WAIT && cnt == CW'(1);
  end
  // the NBA write means a same-edge read still sees the old word
  always_ff @(posedge clk)
    if (LD_EN) mem[LD_IDX] <= LD_DATA;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= 64'd0;
      r_resp   <= 2'b00;
      cnt      <= '0;
    end else begin
      if (enter) begin
        r_valid <= 1'b1;
        r_data  <= rd_data;
        r_resp  <= rd_resp;
      end
      if (state == IDLE) begin
        ar_ready <= !ar_hs;
        if (ar_hs) begin
          addr  <= bus.AR_ADDR;
          cnt   <= d;
          state <= d == '0 ? RESP : WAIT;
        end
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) state <= RESP;
      end else if (bus.R_READY) begin
        state    <= IDLE;
        r_valid  <= 1'b0;
        ar_ready <= 1'b1;
      end
    end
  end
  assign bus.AR_READY = ar_ready;
  assign bus.R_VALID  = r_valid;
  assign bus.R_DATA   = r_data;
  assign bus.R_RESP   = r_resp;
  assign unused       = ^{bus.AR_PROT, off[2:0]};
endmodule

// File: tb/tb_axi4_lite_sram_read_slave.sv
// tb_axi4_lite_sram_read_slave: directed checks of a LATENCY=2 slave and a LATENCY=0 slave sharing one load port
module tb_axi4_lite_sram_read_slave;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_en;
  logic [11:0] ld_idx;
  logic [63:0] ld_data;
  int          total = 0;
  int          bad = 0;
  localparam logic [63:0] W0 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] W1 = 64'hA1A1_B2B2_C3C3_D4D4;
  localparam logic [63:0] W2 = 64'h0F0E_0D0C_0B0A_0908;
  localparam logic [63:0] W3 = 64'hDEAD_BEEF_0000_0003;
  localparam logic [63:0] W3N = 64'h5555_AAAA_5555_AAAA;
  localparam logic [63:0] WL = 64'hFEED_FACE_CAFE_F00D;
  axi4_lite_sram_read_slave_if a_if ();
  axi4_lite_sram_read_slave_if b_if ();
  axi4_lite_sram_read_slave #(.LATENCY(2)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if), .LD_EN(ld_en), .LD_IDX(ld_idx), .LD_DATA(ld_data));
  axi4_lite_sram_read_slave #(.LATENCY(0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if), .LD_EN(ld_en), .LD_IDX(ld_idx), .LD_DATA(ld_data));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic load(input logic [11:0] i, input logic [63:0] v);
    ld_en = 1'b1;
    ld_idx = i;
    ld_data = v;
    tick();
    ld_en = 1'b0;
  endtask
  // read on slave A, keep R_READY low for hold cycles once R_VALID is seen
  task automatic rd_a(input string tag, input logic [63:0] a, input int hold,
                      input logic [63:0] ed, input logic [1:0] er);
    int w, lat;
    w = 0;
    while (!a_if.AR_READY && w < 20) begin tick(); w++; end
    a_if.AR_ADDR = a;
    a_if.AR_VALID = 1'b1;
    a_if.R_READY = 1'b0;
    tick();
    a_if.AR_VALID = 1'b0;
    chk({tag, "_ar_fall"}, 64'(a_if.AR_READY), 64'd0);
    lat = 0;
    while (!a_if.R_VALID && lat < 20) begin tick(); lat++; end
`ifdef AXI_RD_SLAVE_RAND_DELAY_EN
    chk({tag, "_lat"}, 64'(lat <= 9), 64'd1);
`else
    chk({tag, "_lat"}, 64'(lat), 64'd2);
`endif
    chk({tag, "_data"}, a_if.R_DATA, ed);
    chk({tag, "_resp"}, 64'(a_if.R_RESP), 64'(er));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_v"}, 64'(a_if.R_VALID), 64'd1);
      chk({tag, "_hold_d"}, a_if.R_DATA, ed);
      chk({tag, "_hold_r"}, 64'(a_if.R_RESP), 64'(er));
      chk({tag, "_hold_ar"}, 64'(a_if.AR_READY), 64'd0);
    end
    a_if.R_READY = 1'b1;
    tick();
    a_if.R_READY = 1'b0;
    chk({tag, "_rv_fall"}, 64'(a_if.R_VALID), 64'd0);
    chk({tag, "_ar_back"}, 64'(a_if.AR_READY), 64'd1);
  endtask
  initial begin
    int hc [2];
    int rl [2];
    logic [63:0] rd [2];
    int nh, nr;
    logic hs, rh;
    rst_n = 1'b0;
    ld_en = 1'b0;
    ld_idx = '0;
    ld_data = '0;
    a_if.AR_ADDR = '0; a_if.AR_VALID = 1'b0; a_if.AR_PROT = 3'b111; a_if.R_READY = 1'b0;
    b_if.AR_ADDR = '0; b_if.AR_VALID = 1'b0; b_if.AR_PROT = 3'b010; b_if.R_READY = 1'b0;
    repeat (3) tick();
    chk("rst_ar_ready", 64'(a_if.AR_READY), 64'd0);
    chk("rst_r_valid", 64'(a_if.R_VALID), 64'd0);
    chk("rst_r_data", a_if.R_DATA, 64'd0);
    chk("rst_r_resp", 64'(a_if.R_RESP), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_exit_ar_ready", 64'(a_if.AR_READY), 64'd1);
    load(12'd0, W0);
    load(12'd1, W1);
    load(12'd2, W2);
    load(12'd3, W3);
    load(12'd4095, WL);
    rd_a("w0", 64'h8000_0000, 0, W0, 2'b00);
    rd_a("w0_hold", 64'h8000_0000, 5, W0, 2'b00);
    rd_a("misalign", 64'h8000_0004, 0, 64'd0, 2'b10);
    rd_a("below", 64'h7FFF_FFF8, 0, 64'd0, 2'b11);
    rd_a("above", 64'h8000_8000, 0, 64'd0, 2'b11);
    rd_a("last", 64'h8000_7FF8, 0, WL, 2'b00);
    // reset while slave A waits out its latency
    a_if.AR_ADDR = 64'h8000_0008;
    a_if.AR_VALID = 1'b1;
    tick();
    a_if.AR_VALID = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_ar0", 64'(a_if.AR_READY), 64'd0);
    chk("mid_rst_rv0", 64'(a_if.R_VALID), 64'd0);
    tick();
    chk("mid_rst_ar1", 64'(a_if.AR_READY), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_no_rv", 64'(a_if.R_VALID), 64'd0);
    end
    rd_a("after_rst", 64'h8000_0010, 0, W2, 2'b00);
    // back-to-back on slave B with AR_VALID held high
    b_if.AR_ADDR = 64'h8000_0008;
    b_if.AR_VALID = 1'b1;
    b_if.R_READY = 1'b1;
    nh = 0;
    nr = 0;
    for (int c = 0; c < 60 && nr < 2; c++) begin
      hs = b_if.AR_VALID && b_if.AR_READY;
      rh = b_if.R_VALID && b_if.R_READY;
      if (rh && nr < nh) begin
        rd[nr] = b_if.R_DATA;
        rl[nr] = c - hc[nr] - 1;
        nr++;
      end
      tick();
      if (hs && nh < 2) begin
        hc[nh] = c;
        nh++;
        b_if.AR_ADDR = 64'h8000_0010;
        if (nh == 2) b_if.AR_VALID = 1'b0;
      end
    end
    b_if.AR_VALID = 1'b0;
    b_if.R_READY = 1'b0;
    chk("b2b_beats", 64'(nr), 64'd2);
    if (nr == 2) begin
      chk("b2b_d0", rd[0], W1);
      chk("b2b_d1", rd[1], W2);
      chk("b2b_spacing", 64'(hc[1] - hc[0]), 64'(rl[0] + 2));
`ifdef AXI_RD_SLAVE_RAND_DELAY_EN
      chk("b2b_lat0", 64'(rl[0] <= 7), 64'd1);
      chk("b2b_lat1", 64'(rl[1] <= 7), 64'd1);
`else
      chk("b2b_lat0", 64'(rl[0]), 64'd0);
      chk("b2b_lat1", 64'(rl[1]), 64'd0);
`endif
    end
`ifndef AXI_RD_SLAVE_RAND_DELAY_EN
    // load and zero-latency read of the same word on one edge
    tick();
    chk("coll_ar_ready", 64'(b_if.AR_READY), 64'd1);
    b_if.AR_ADDR = 64'h8000_0018;
    b_if.AR_VALID = 1'b1;
    ld_en = 1'b1;
    ld_idx = 12'd3;
    ld_data = W3N;
    tick();
    ld_en = 1'b0;
    b_if.AR_VALID = 1'b0;
    chk("coll_rv", 64'(b_if.R_VALID), 64'd1);
    chk("coll_old", b_if.R_DATA, W3);
    b_if.R_READY = 1'b1;
    tick();
    b_if.R_READY = 1'b0;
    chk("coll_done", 64'(b_if.R_VALID), 64'd0);
`endif
    rd_a("new_w3", 64'h8000_0018, 0, W3N, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
